// File: rtl/seven_seg_scan.sv
// -----------------------------------------------------------------------------
// seven_seg_scan
//
// Time-multiplexed driver for an NDIG-digit seven-segment display. A prescaler
// divides clk by DIV+1 to make a refresh tick. Each tick advances to the next
// digit and registers that digit's segment pattern and one-hot enable.
//
// Pattern data is double-buffered. `load` captures seg_in into a staging
// register, and the staged value moves to the shadow register only when the
// scan wraps to digit 0. All digits of one frame therefore come from one
// snapshot, and an update never tears mid-frame.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   en          in   scan enable; 0 freezes prescaler, digit index and outputs
//   seg_in      in   7*NDIG pattern bits; digit k at [7k+6:7k], bit 0 = seg a
//   load        in   1-cycle strobe: capture seg_in into the staging register
//   blank_mask  in   bit k = 1 forces digit k dark (sampled at its tick)
//   segment     out  registered segment drive for the active digit
//   anode       out  registered one-hot digit enable
//   digit_idx   out  index of the digit currently driven
//   sig         out  1-cycle pulse on each refresh tick
//   frame_done  out  1-cycle pulse when the scan wraps to digit 0
// -----------------------------------------------------------------------------
module seven_seg_scan #(
    parameter int NDIG       = 4,
    parameter int DIV        = 750,
    parameter int CBITS      = 10,
    parameter bit ACTIVE_LOW = 1'b0,
    localparam int IW        = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [7*NDIG-1:0]   seg_in,
    input  logic                load,
    input  logic [NDIG-1:0]     blank_mask,
    output logic [6:0]          segment,
    output logic [NDIG-1:0]     anode,
    output logic [IW-1:0]       digit_idx,
    output logic                sig,
    output logic                frame_done
);

    localparam logic [CBITS-1:0] DIV_C    = CBITS'(DIV);
    localparam logic [IW-1:0]    LAST_IDX = IW'(NDIG - 1);
    // XOR masks that turn logical "lit" values into the physical drive level.
    localparam logic [6:0]       SEG_FLIP = {7{ACTIVE_LOW}};
    localparam logic [NDIG-1:0]  AN_FLIP  = {NDIG{ACTIVE_LOW}};

    logic [CBITS-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [7*NDIG-1:0] stage_q, stage_d;
    logic [7*NDIG-1:0] shadow_q, shadow_d;
    logic              pending_q, pending_d;
    logic [6:0]        segment_q, segment_d;
    logic [NDIG-1:0]   anode_q, anode_d;
    logic              sig_q, sig_d;
    logic              frame_done_q, frame_done_d;

    logic              tick;
    logic              wrap;
    logic [IW-1:0]     nxt;
    logic [7*NDIG-1:0] frame_src;
    logic [6:0]        seg_field;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        stage_d      = stage_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        segment_d    = segment_q;
        anode_d      = anode_q;
        sig_d        = 1'b0;
        frame_done_d = 1'b0;

        tick = en && (cnt_q == DIV_C);
        nxt  = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        wrap = tick && (nxt == '0);

        // Data for the digit selected by this tick. At a wrap, a load in the
        // same cycle wins over staged data. Digit 0 sees the new frame at once,
        // without waiting a cycle for the shadow register.
        frame_src = shadow_q;
        if (wrap) begin
            if (load) begin
                frame_src = seg_in;
            end else if (pending_q) begin
                frame_src = stage_q;
            end
        end
        seg_field = frame_src[7*nxt +: 7];

        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CBITS'(1);
        end

        if (tick) begin
            idx_d        = nxt;
            anode_d      = AN_FLIP ^ (NDIG'(1) << nxt);
            segment_d    = SEG_FLIP ^ (blank_mask[nxt] ? 7'h00 : seg_field);
            sig_d        = 1'b1;
            frame_done_d = wrap;
        end

        if (wrap) begin
            shadow_d = frame_src;
        end

        // A load at a wrap is consumed immediately, so nothing stays pending.
        if (load) begin
            stage_d   = seg_in;
            pending_d = !wrap;
        end else if (wrap) begin
            pending_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments. Every flop then
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= LAST_IDX;
            stage_q      <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            segment_q    <= SEG_FLIP;
            anode_q      <= AN_FLIP;
            sig_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            stage_q      <= stage_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            segment_q    <= segment_d;
            anode_q      <= anode_d;
            sig_q        <= sig_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign segment    = segment_q;
    assign anode      = anode_q;
    assign digit_idx  = idx_q;
    assign sig        = sig_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_scan
//
// Drives two copies of seven_seg_scan (NDIG=4, DIV=3) from the same inputs:
// one active-high and one active-low. The reference model counts enabled clock
// edges since reset. Every (DIV+1)th enabled edge is a tick, and tick number t
// shows digit (t-1) mod NDIG. A frame snapshot is taken at each digit-0 tick
// from the most recent load seen since the previous snapshot.
// -----------------------------------------------------------------------------
module tb_seven_seg_scan;

    localparam int NDIG  = 4;
    localparam int DIV   = 3;
    localparam int CBITS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [27:0] seg_in = '0;
    logic [3:0]  blank_mask = '0;

    logic [6:0]  seg_a, seg_b;
    logic [3:0]  an_a, an_b;
    logic [1:0]  idx_a, idx_b;
    logic        sig_a, sig_b, fd_a, fd_b;

    int n_cmp  = 0;
    int n_fail = 0;

    seven_seg_scan #(.NDIG(NDIG), .DIV(DIV), .CBITS(CBITS), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .seg_in(seg_in), .load(load),
        .blank_mask(blank_mask), .segment(seg_a), .anode(an_a),
        .digit_idx(idx_a), .sig(sig_a), .frame_done(fd_a)
    );

    seven_seg_scan #(.NDIG(NDIG), .DIV(DIV), .CBITS(CBITS), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .en(en), .seg_in(seg_in), .load(load),
        .blank_mask(blank_mask), .segment(seg_b), .anode(an_b),
        .digit_idx(idx_b), .sig(sig_b), .frame_done(fd_b)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          n_en;
    logic [1:0]  m_idx;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_sig, m_fd;
    logic [27:0] m_shadow, m_latest;
    logic        m_fresh;

    function automatic logic [6:0] digit_of(input logic [27:0] f, input int d);
        logic [27:0] sh;
        sh = f >> (7 * d);
        return sh[6:0];
    endfunction

    // Frame data that digit d would display when selected on this edge.
    function automatic logic [27:0] frame_for(input int d);
        if (d != 0) return m_shadow;
        if (load) return seg_in;
        if (m_fresh) return m_latest;
        return m_shadow;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n_en     <= 0;
            m_idx    <= 2'd3;
            m_an     <= 4'h0;
            m_seg    <= 7'h00;
            m_sig    <= 1'b0;
            m_fd     <= 1'b0;
            m_shadow <= '0;
            m_latest <= '0;
            m_fresh  <= 1'b0;
        end else begin
            m_sig <= 1'b0;
            m_fd  <= 1'b0;
            if (load) begin
                m_latest <= seg_in;
                m_fresh  <= 1'b1;
            end
            if (en) begin
                n_en <= n_en + 1;
                if ((n_en + 1) % (DIV + 1) == 0) begin
                    int d;
                    d = ((n_en + 1) / (DIV + 1) - 1) % NDIG;
                    m_idx <= 2'(d);
                    m_an  <= 4'(1 << d);
                    m_seg <= blank_mask[d] ? 7'h00 : digit_of(frame_for(d), d);
                    m_sig <= 1'b1;
                    m_fd  <= (d == 0);
                    if (d == 0) begin
                        m_shadow <= frame_for(0);
                        m_fresh  <= 1'b0;
                    end
                end
            end
        end
    end

    logic [14:0] obs, obs_al, exp_v, exp_al;
    assign obs    = {idx_a, an_a, seg_a, sig_a, fd_a};
    assign obs_al = {idx_b, an_b, seg_b, sig_b, fd_b};
    assign exp_v  = {m_idx, m_an, m_seg, m_sig, m_fd};
    assign exp_al = {m_idx, ~m_an, ~m_seg, m_sig, m_fd};

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        load = 1'b0;
        en = 1'b1;
        blank_mask = '0;
        seg_in = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs !== {2'd3, 4'h0, 7'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs, {2'd3, 4'h0, 7'h00, 2'b00});
        end
        n_cmp++;
        if (obs_al !== {2'd3, 4'hF, 7'h7F, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state_al: got %h want %h", obs_al, {2'd3, 4'hF, 7'h7F, 2'b00});
        end
    endtask

    task automatic test_scan_timing();
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL scan_model k=%0d: got %h want %h", k, obs, exp_v);
            end
            n_cmp++;
            if (sig_a !== 1'(k % 4 == 0)) begin
                n_fail++;
                $display("FAIL scan_sig k=%0d: got %b want %b", k, sig_a, (k % 4 == 0));
            end
            if (k == 4) begin
                n_cmp++;
                if ({idx_a, an_a, seg_a, fd_a} !== {2'd0, 4'b0001, 7'h00, 1'b1}) begin
                    n_fail++;
                    $display("FAIL first_tick: got %h want %h", {idx_a, an_a, seg_a, fd_a},
                             {2'd0, 4'b0001, 7'h00, 1'b1});
                end
            end
            if (k % 4 == 0) begin
                logic [3:0] want;
                want = 4'(1 << ((k / 4 - 1) % 4));
                n_cmp++;
                if (an_a !== want) begin
                    n_fail++;
                    $display("FAIL anode_rotate k=%0d: got %b want %b", k, an_a, want);
                end
            end
        end
    endtask

    task automatic test_load_sequence();
        logic [6:0] want;
        do_reset();
        seg_in = {7'h06, 7'h5B, 7'h4F, 7'h66};
        load = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL load_model k=%0d: got %h want %h", k, obs, exp_v);
            end
            if (k % 4 == 0) begin
                case (k)
                    4:       want = 7'h66;
                    8:       want = 7'h4F;
                    12:      want = 7'h5B;
                    16:      want = 7'h06;
                    20:      want = 7'h07;
                    default: want = 7'h6D;
                endcase
                n_cmp++;
                if (seg_a !== want) begin
                    n_fail++;
                    $display("FAIL load_seq k=%0d: got %h want %h", k, seg_a, want);
                end
            end
            load = 1'b0;
            // A second load while digit 1 is showing must wait for the next frame.
            if (k == 9) begin
                seg_in = {7'h7F, 7'h3F, 7'h6D, 7'h07};
                load = 1'b1;
            end
        end
    endtask

    task automatic test_wrap_load();
        logic [6:0] want;
        do_reset();
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL wrap_model k=%0d: got %h want %h", k, obs, exp_v);
            end
            if (k == 20 || k == 24 || k == 36) begin
                want = (k == 24) ? 7'h33 : 7'h44;
                n_cmp++;
                if (seg_a !== want) begin
                    n_fail++;
                    $display("FAIL wrap_load k=%0d: got %h want %h", k, seg_a, want);
                end
            end
            load = 1'b0;
            if (k == 19) begin
                // Edge 20 has cnt==DIV and idx==3: the load lands on the wrap tick.
                seg_in = {7'h11, 7'h22, 7'h33, 7'h44};
                load = 1'b1;
            end else if (k == 20) begin
                seg_in = {7'h55, 7'h55, 7'h55, 7'h55};
            end
        end
    endtask

    task automatic test_blank();
        do_reset();
        seg_in = {4{7'h7F}};
        blank_mask = 4'b0100;
        load = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            load = 1'b0;
            n_cmp++;
            if (obs !== exp_v || obs_al !== exp_al) begin
                n_fail++;
                $display("FAIL blank_model k=%0d: got %h/%h want %h/%h", k, obs, obs_al, exp_v, exp_al);
            end
            if (k % 4 == 0) begin
                bit blanked;
                blanked = (((k / 4) - 1) % 4) == 2;
                n_cmp++;
                if (seg_a !== (blanked ? 7'h00 : 7'h7F)) begin
                    n_fail++;
                    $display("FAIL blank_seg k=%0d: got %h want %h", k, seg_a, blanked ? 7'h00 : 7'h7F);
                end
                n_cmp++;
                if (seg_b !== (blanked ? 7'h7F : 7'h00)) begin
                    n_fail++;
                    $display("FAIL blank_seg_al k=%0d: got %h want %h", k, seg_b, blanked ? 7'h7F : 7'h00);
                end
                if (blanked) begin
                    n_cmp++;
                    if (an_b !== 4'b1011) begin
                        n_fail++;
                        $display("FAIL blank_anode_al: got %b want 1011", an_b);
                    end
                end
            end
        end
    endtask

    task automatic test_enable_freeze();
        do_reset();
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL en_model k=%0d: got %h want %h", k, obs, exp_v);
            end
            if (k >= 7 && k <= 16) begin
                n_cmp++;
                if ({sig_a, idx_a, an_a} !== {1'b0, 2'd0, 4'b0001}) begin
                    n_fail++;
                    $display("FAIL en_frozen k=%0d: got %h want %h", k, {sig_a, idx_a, an_a}, 7'b0000001);
                end
            end
            if (k == 17 || k == 18) begin
                n_cmp++;
                if ({sig_a, idx_a} !== ((k == 18) ? 3'b101 : 3'b000)) begin
                    n_fail++;
                    $display("FAIL en_resume k=%0d: got %b want %b", k, {sig_a, idx_a},
                             (k == 18) ? 3'b101 : 3'b000);
                end
            end
            if (k == 6) en = 1'b0;   // cnt holds at 2
            if (k == 16) en = 1'b1;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL arst_pre k=%0d: got %h want %h", k, obs, exp_v);
            end
            load = 1'b0;
            if (k == 12) begin
                seg_in = {4{7'h3C}};
                load = 1'b1;
            end
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({idx_a, an_a, seg_a, idx_b, an_b, seg_b} !== {2'd3, 4'h0, 7'h00, 2'd3, 4'hF, 7'h7F}) begin
            n_fail++;
            $display("FAIL arst_dark: got %h want %h", {idx_a, an_a, seg_a, idx_b, an_b, seg_b},
                     {2'd3, 4'h0, 7'h00, 2'd3, 4'hF, 7'h7F});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL arst_post k=%0d: got %h want %h", k, obs, exp_v);
            end
            if (k == 4) begin
                n_cmp++;
                if ({sig_a, fd_a, idx_a, an_a, seg_a} !== {1'b1, 1'b1, 2'd0, 4'b0001, 7'h00}) begin
                    n_fail++;
                    $display("FAIL arst_restart: got %h want %h", {sig_a, fd_a, idx_a, an_a, seg_a},
                             {1'b1, 1'b1, 2'd0, 4'b0001, 7'h00});
                end
            end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL rand k=%0d: got %h want %h", k, obs, exp_v);
            end
            n_cmp++;
            if (obs_al !== exp_al) begin
                n_fail++;
                $display("FAIL rand_al k=%0d: got %h want %h", k, obs_al, exp_al);
            end
            en         = ($urandom_range(0, 9) != 0);
            load       = ($urandom_range(0, 7) == 0);
            seg_in     = 28'($urandom);
            blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            if ($urandom_range(0, 249) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_timing();
        test_load_sequence();
        test_wrap_load();
        test_blank();
        test_enable_freeze();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Parametrised time-multiplexed driver for an NDIG-digit common-anode/common-cathode seven-segment display; successor to the 2-digit fixed-rate scanner.
- Divides clk by DIV+1 to produce a refresh tick. Each tick selects the next digit, driving its segment pattern and one-hot digit enable.
- Adds per-digit blanking, output polarity selection, scan enable, and frame-synchronous double-buffered loading so a display update never tears mid-frame.

Parameters:
- NDIG, 4, number of digits scanned (>=2).
- DIV, 750, refresh tick every DIV+1 enabled clocks.
- CBITS, 10, prescaler width; must satisfy 2^CBITS > DIV.
- ACTIVE_LOW, 0, 1 = segment and anode outputs are inverted (0 lights).
- Local IW = max(1, clog2(NDIG)).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  scan enable; 0 freezes prescaler, digit index and outputs.
- seg_in  in  7*NDIG  patterns; digit k = seg_in[7k+6:7k], digit 0 at LSBs; bit 0 = segment a.
- load  in  1  1-cycle strobe: capture seg_in into staging register.
- blank_mask  in  NDIG  bit k=1 forces digit k segments off (sampled at tick).
- segment  out  7  registered segment drive for the active digit.
- anode  out  NDIG  registered one-hot digit enable.
- digit_idx  out  IW  index of digit currently driven.
- sig  out  1  1-cycle pulse on each refresh tick.
- frame_done  out  1  1-cycle pulse when scan wraps to digit 0 (coincident with sig).

Behaviour:
- Reset (async, immediate) values:
  - cnt=0, idx=NDIG-1, stage=0, shadow=0, pending=0.
  - sig=0, frame_done=0, digit_idx=NDIG-1.
  - segment = all off (7'h00, or 7'h7F if ACTIVE_LOW); anode = all off (0, or all 1s if ACTIVE_LOW).
- Prescaler (en=1):
  - cnt!=DIV: cnt<=cnt+1, sig<=0.
  - cnt==DIV: cnt<=0, sig<=1 (tick).
  - Ticks are therefore DIV+1 cycles apart; the first tick after reset comes at the (DIV+1)th enabled edge.
- en=0: cnt, idx, segment, anode, digit_idx hold; sig and frame_done forced 0. load still captures.
- On tick:
  - nxt = (idx==NDIG-1) ? 0 : idx+1; idx<=nxt; digit_idx<=nxt.
  - anode<=one-hot(nxt), polarity-adjusted.
  - segment<=field nxt of the shadow value (defined below), or 0 if blank_mask[nxt], then polarity-adjusted.
  - frame_done<=1 iff nxt==0.
  - Outputs change on the edge where cnt==DIV was sampled; there is no extra pipeline stage.
- Double buffer:
  - load=1: stage<=seg_in, pending<=1. The last load before the frame boundary wins.
  - At a tick with nxt==0 and pending=1: shadow<=stage, pending<=0. Digit 0 of that same tick uses the new data (bypass).
  - If load coincides with a wrap tick, seg_in is bypassed directly into shadow and the segment output; pending stays 0.
  - Shadow never changes at non-wrap ticks, so all digits of one frame come from one snapshot.
- Initial frame: the first tick after reset selects digit 0 and asserts frame_done, so a load issued before the first tick is displayed in frame 0.
- Reset mid-frame: the scan restarts from the reset state, pending data is discarded, and outputs go dark immediately.
- blank_mask is not buffered; it takes effect at the next tick of the affected digit.

Test Plan:
- Reset, NDIG=4, DIV=3, en=1, no load: first sig at cycle 4 after rst release; digit_idx=0, anode=4'b0001, segment=7'h00, frame_done=1. Sig repeats every 4 cycles and anode rotates 0001->0010->0100->1000->0001.
- load at cycle 1 with seg_in={7'h06,7'h5B,7'h4F,7'h66}: segment sequence over ticks is 7'h66,7'h4F,7'h5B,7'h06. A second load mid-frame (at digit 1) with new data changes nothing until the next digit-0 tick.
- load asserted in the exact cycle cnt==DIV and idx==3: digit 0 immediately shows the new seg_in[6:0]; pending reads 0 afterwards (no repeat update).
- blank_mask=4'b0100 with all patterns 7'h7F: segment=7'h00 while anode=0100, 7'h7F otherwise. With ACTIVE_LOW=1, the blanked digit gives segment=7'h7F and anode=4'b1011.
- en dropped for 10 cycles mid-count (cnt=2): outputs frozen, no sig. After re-enable, the next sig arrives exactly 2 enabled cycles later.
- rst pulsed asynchronously between edges during digit 2: anode and segment go dark without a clock edge; after release, timing matches scenario 1.
